// File: rtl/cnn_conv2d_stream.sv
// cnn_conv2d_stream: streaming KxK valid-region 2D convolution, saturating sum, optional ReLU (CNN_CONV_RELU_EN)
// Latency: out_valid rises one cycle after the pixel that completes a window is accepted
// Backpressure: pix_ready drops while a result is held unaccepted; out_data/out_last held stable
module cnn_conv2d_stream #(
    parameter int DW    = 4,
    parameter int WW    = 4,
    parameter int OW    = 10,
    parameter int K     = 3,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 w_load,
    input  logic                 w_valid,
    input  logic signed [WW-1:0] w_data,
    output logic                 w_loaded,
    input  logic                 start,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    input  logic [DW-1:0]        pix_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);
    localparam int KK = K * K;
    localparam int NP = IMG_W * IMG_H;
    localparam int PW = DW + WW + 1;
    localparam int AW = PW + $clog2(KK);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int NW = $clog2(NP + 1);
    localparam int IW = $clog2(KK);

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_WIN   = CW'(K - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_WIN   = RW'(K - 1);
    localparam logic [NW-1:0] PIX_TOTAL = NW'(NP);
    localparam logic [IW-1:0] TAP_LAST  = IW'(KK - 1);
    localparam logic signed [AW-1:0] ACC_MAX = AW'((1 << (OW - 1)) - 1);
    localparam logic signed [AW-1:0] ACC_MIN = ~ACC_MAX;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic signed [WW-1:0] wts [KK];
    logic [IW-1:0]        tap_idx;
    // lbuf[0] is the oldest buffered row; lbuf[K-2] the row just above the current one
    logic [DW-1:0]        lbuf [K-1][IMG_W];
    logic [DW-1:0]        win [K][K];
    logic [DW-1:0]        win_nxt [K][K];
    logic [CW-1:0]        col;
    logic [RW-1:0]        row;
    logic [NW-1:0]        pix_cnt;
    logic                 pix_acc, win_done, load_go, frame_go;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] acc;
    logic signed [OW-1:0] res;

    assign load_go   = (state == IDLE) && w_load;
    assign frame_go  = (state == IDLE) && !w_load && start && w_loaded;
    assign pix_ready = (state == RUN) && (pix_cnt != PIX_TOTAL) && (!out_valid || out_ready);
    assign pix_acc   = pix_valid && pix_ready;
    assign win_done  = (col >= COL_WIN) && (row >= ROW_WIN);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: w_load takes priority over start in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (w_load) state_nxt = LOAD;
                  else if (start && w_loaded) state_nxt = RUN;
            LOAD: if (w_valid && tap_idx == TAP_LAST) state_nxt = IDLE;
            RUN:  if (out_valid && out_ready && out_last) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Weight store; a new load invalidates the held set until all taps arrive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < KK; i++) wts[i] <= '0;
            tap_idx  <= '0;
            w_loaded <= 1'b0;
        end else if (load_go) begin
            tap_idx  <= '0;
            w_loaded <= 1'b0;
        end else if (state == LOAD && w_valid) begin
            wts[tap_idx] <= w_data;
            tap_idx      <= tap_idx + IW'(1);
            if (tap_idx == TAP_LAST) w_loaded <= 1'b1;
        end
    end

    // Shifted window including the incoming column, then multiply-accumulate and saturate
    always_comb begin
        acc  = '0;
        prod = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K - 1; j++) win_nxt[i][j] = win[i][j+1];
        end
        for (int i = 0; i < K - 1; i++) win_nxt[i][K-1] = lbuf[i][col];
        win_nxt[K-1][K-1] = pix_data;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                prod = PW'($signed({1'b0, win_nxt[i][j]})) * PW'(wts[i*K+j]);
                acc  = acc + AW'(prod);
            end
        end
        if (acc > ACC_MAX)      res = OW'(ACC_MAX);
        else if (acc < ACC_MIN) res = OW'(ACC_MIN);
        else                    res = OW'(acc);
`ifdef CNN_CONV_RELU_EN
        if (res[OW-1]) res = '0;
`endif
    end

    // Raster counters, line buffers and window advance once per accepted pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col     <= '0;
            row     <= '0;
            pix_cnt <= '0;
            for (int i = 0; i < K - 1; i++)
                for (int j = 0; j < IMG_W; j++) lbuf[i][j] <= '0;
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++) win[i][j] <= '0;
        end else if (frame_go) begin
            col     <= '0;
            row     <= '0;
            pix_cnt <= '0;
        end else if (pix_acc) begin
            pix_cnt <= pix_cnt + NW'(1);
            if (col == COL_LAST) begin
                col <= '0;
                row <= row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
            for (int i = 0; i < K - 2; i++) lbuf[i][col] <= lbuf[i+1][col];
            lbuf[K-2][col] <= pix_data;
            win <= win_nxt;
        end
    end

    // Result register: loads on a completed window, otherwise clears on handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (pix_acc && win_done) begin
            out_valid <= 1'b1;
            out_data  <= res;
            out_last  <= (row == ROW_LAST) && (col == COL_LAST);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cnn_conv2d_stream.sv
// tb_cnn_conv2d_stream: directed bench for the streaming convolution engine
// Latency: expectations track the one-cycle result latency per accepted pixel
// Backpressure: stalls out_ready after the first result and checks hold behaviour
module tb_cnn_conv2d_stream;
    localparam int DW = 4, WW = 4, OW = 10, K = 3, IMG_W = 8, IMG_H = 8;
    localparam int NP   = IMG_W * IMG_H;
    localparam int OUTW = IMG_W - K + 1;
    localparam int NRES = OUTW * (IMG_H - K + 1);

    logic                 clk, rst_n;
    logic                 w_load, w_valid, w_loaded, start;
    logic signed [WW-1:0] w_data;
    logic                 pix_valid, pix_ready;
    logic [DW-1:0]        pix_data;
    logic                 out_valid, out_ready, out_last, busy, done;
    logic signed [OW-1:0] out_data;

    int vectors = 0;
    int fails   = 0;

    cnn_conv2d_stream #(.DW(DW), .WW(WW), .OW(OW), .K(K), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk(clk), .rst_n(rst_n),
        .w_load(w_load), .w_valid(w_valid), .w_data(w_data), .w_loaded(w_loaded),
        .start(start),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    // mode 0: constant pixel value; mode 1: ramp row*IMG_W+col modulo 2^DW
    function automatic logic [DW-1:0] pix_of(input int mode, input int val, input int idx);
        if (idx >= NP) return '0;
        if (mode == 1) return DW'(((idx / IMG_W) * IMG_W + (idx % IMG_W)) % (1 << DW));
        return DW'(val);
    endfunction

    // Ramp with centre-tap kernel: result equals window centre pixel
    function automatic int exp_res(input int mode, input int expv, input int ri);
        int r, c;
        if (mode != 1) return expv;
        r = ri / OUTW;
        c = ri % OUTW;
        return ((r + K / 2) * IMG_W + (c + K / 2)) % (1 << DW);
    endfunction

    task automatic load_w(input int v, input bit centre, input bit with_start);
        w_load = 1'b1;
        start  = with_start;
        @(posedge clk); #1;
        w_load = 1'b0;
        start  = 1'b0;
        chk("load_busy", busy, 1);
        chk("load_w_loaded_low", w_loaded, 0);
        for (int i = 0; i < K * K; i++) begin
            w_valid = 1'b1;
            w_data  = centre ? ((i == (K * K) / 2) ? 4'sd1 : 4'sd0) : WW'(v);
            @(posedge clk); #1;
        end
        w_valid = 1'b0;
        chk("load_w_loaded_high", w_loaded, 1);
        chk("load_idle", busy, 0);
    endtask

    task automatic run_frame(input int pmode, input int pval, input int expv, input int stall);
        int pi, ri, cyc, stall_left;
        bit stalled, exp_vld, accepted;
        pi = 0; ri = 0; cyc = 0; stall_left = 0; stalled = 0; exp_vld = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("run_busy", busy, 1);
        while (ri < NRES && cyc < 2000) begin
            chk("out_valid_seq", out_valid, exp_vld);
            if (out_valid && ri == 0 && stall > 0 && !stalled) begin
                stall_left = stall;
                stalled    = 1'b1;
            end
            out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            pix_valid = (pi < NP);
            pix_data  = pix_of(pmode, pval, pi);
            #1;
            if (out_valid && !out_ready) begin
                chk("hold_data", out_data, exp_res(pmode, expv, ri));
                chk("hold_pix_ready", pix_ready, 0);
            end
            accepted = pix_valid && pix_ready;
            exp_vld  = (accepted && (pi % IMG_W) >= K - 1 && (pi / IMG_W) >= K - 1) ||
                       (out_valid && !out_ready);
            if (out_valid && out_ready) begin
                chk("result", out_data, exp_res(pmode, expv, ri));
                chk("last_flag", out_last, (ri == NRES - 1) ? 1 : 0);
                ri++;
            end
            if (accepted) pi++;
            cyc++;
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;
        out_ready = 1'b1;
        chk("result_count", ri, NRES);
        chk("pixel_count", pi, NP);
        chk("out_valid_end", out_valid, 0);
        chk("done_pulse", done, 1);
        @(posedge clk); #1;
        chk("done_cleared", done, 0);
        chk("idle_after", busy, 0);
    endtask

    initial begin
        int n, cyc;
        rst_n = 1'b0; w_load = 1'b0; w_valid = 1'b0; w_data = '0; start = 1'b0;
        pix_valid = 1'b0; pix_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_w_loaded", w_loaded, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // start without weights is ignored
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("nowt_busy", busy, 0);
        chk("nowt_pix_ready", pix_ready, 0);

        // unit kernel on unit image; a stray w_valid in IDLE must not corrupt weights
        load_w(1, 1'b0, 1'b0);
        w_valid = 1'b1; w_data = -4'sd8;
        @(posedge clk); #1;
        w_valid = 1'b0;
        chk("stray_w_valid", w_loaded, 1);
        run_frame(0, 1, 9, 0);

        // positive saturation; w_load coinciding with start enters LOAD
        load_w(7, 1'b0, 1'b1);
        run_frame(0, 15, 511, 0);

        // negative saturation, or clamp to zero with ReLU
        load_w(-8, 1'b0, 1'b0);
`ifdef CNN_CONV_RELU_EN
        run_frame(0, 15, 0, 0);
`else
        run_frame(0, 15, -512, 0);
`endif

        // ramp image through a centre tap, with a 5-cycle output stall
        load_w(0, 1'b1, 1'b0);
        run_frame(1, 0, 0, 5);

        // reset part way through a frame
        load_w(1, 1'b0, 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; cyc = 0;
        while (n < 20 && cyc < 200) begin
            pix_valid = 1'b1;
            pix_data  = 4'd1;
            #1;
            if (pix_ready) n++;
            @(posedge clk); #1;
            cyc++;
        end
        pix_valid = 1'b0;
        chk("midrst_pixels", n, 20);
        rst_n = 1'b0;
        #1;
        chk("midrst_pix_ready", pix_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_out_last", out_last, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_w_loaded", w_loaded, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("postrst_start_ignored", busy, 0);
        load_w(1, 1'b0, 1'b0);
        run_frame(0, 2, 18, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/cnn_conv2d_stream.md
Name: cnn_conv2d_stream

Overview:
- Parametrised successor to the single-layer CNN datapath: a streaming KxK 2D convolution engine with line buffers, saturating accumulation and ReLU.
- Holds KxK signed weights loaded serially. Consumes an IMG_W x IMG_H unsigned image in raster order and emits valid-region (no padding) results with ready/valid backpressure.
- Sits between the image source and the next layer or pooling stage.

Parameters:
- DW, 4, pixel width (unsigned)
- WW, 4, weight width (signed)
- OW, 10, result width (signed, saturated)
- K, 3, kernel size (KxK taps, K>=2)
- IMG_W, 8, image width in pixels (IMG_W>=K)
- IMG_H, 8, image height in pixels (IMG_H>=K)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- w_load  in  1  pulse: begin weight load (accepted in IDLE only)
- w_valid  in  1  weight beat valid (LOAD state)
- w_data  in  WW  signed weight, row-major order, tap (0,0) first
- w_loaded  out  1  full weight set held
- start  in  1  pulse: begin frame (accepted in IDLE with w_loaded=1)
- pix_valid  in  1  pixel valid
- pix_ready  out  1  pixel accepted when pix_valid && pix_ready
- pix_data  in  DW  unsigned pixel, raster order
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_data  out  OW  signed result
- out_last  out  1  marks final result of frame
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset: all outputs 0, state IDLE, weights/line buffers/counters cleared, w_loaded=0.
- FSM states: IDLE, LOAD, RUN, DONE.
  - IDLE --w_load--> LOAD. If w_load and start coincide, w_load wins.
  - IDLE --start && w_loaded--> RUN. start in IDLE without weights is ignored. start outside IDLE is ignored.
  - LOAD: w_loaded drops to 0 on entry. Each w_valid beat stores one weight. After K*K beats go to IDLE with w_loaded=1. w_valid outside LOAD is ignored.
  - RUN: accepts exactly IMG_W*IMG_H pixels. Moves to DONE when the last result handshakes.
  - DONE: done=1 for one cycle, then IDLE. Weights are retained across frames.
- pix_ready = (state==RUN) && pixels remaining && (!out_valid || out_ready).
- Counters: col 0..IMG_W-1 and row 0..IMG_H-1, advanced per accepted pixel; col wraps to 0 with row++.
- Line buffers: K-1 rows of IMG_W pixels. The KxK window shift register updates on each accepted pixel.
- A window is complete when the accepted pixel has col>=K-1 && row>=K-1.
- Result count per frame: (IMG_W-K+1)*(IMG_H-K+1), i.e. 36 at defaults.
- Arithmetic:
  - Each product is unsigned pixel (zero-extended to DW+1) times signed weight.
  - Accumulator width = DW+WW+1+clog2(K*K); no internal overflow.
  - Sum is saturated to signed OW range [-2^(OW-1), 2^(OW-1)-1]. At defaults: [-512, 511].
- Latency: out_valid rises the cycle after the completing pixel is accepted.
- Output hold: out_data and out_last are held stable while out_valid && !out_ready. out_valid clears on handshake unless a new result loads the same cycle.
- out_last = 1 with the result for window position (IMG_H-1, IMG_W-1).
- Reset mid-frame or mid-load: immediate return to reset state. A partial frame is discarded; a partial weight set is invalid (w_loaded=0).

Optional Feature:
- Macro: CNN_CONV_RELU_EN.
- Defined: the saturated result passes through ReLU, so negative values output 0.
- Undefined: the signed saturated value is output unchanged.

Test Plan:
- Load 9 weights of 1; start; stream 64 pixels of 1 with out_ready=1 -> 36 results each 9, out_last on the 36th, done pulse, busy=0.
- Weights all 7, pixels all 15 -> sum 945 saturates to 511. Weights all -8, pixels 15, RELU_EN undefined -> -1080 saturates to -512; with RELU_EN defined -> 0.
- Ramp image pix = row*8+col (mod 16); weights with centre=1, rest=0 -> each result equals the centre pixel of its window (first result 9).
- Hold out_ready=0 for 5 cycles after the first result -> out_data stable at 9, pix_ready=0, no pixel or result lost; total still 36.
- start with w_loaded=0 -> stays IDLE, pix_ready=0. A w_load then 9 beats -> w_loaded=1, and start is then accepted.
- Assert rst_n=0 after 20 pixels -> all outputs 0, w_loaded=0. A start after release is ignored until weights are reloaded.
